// File: rtl/wolfram_lut.sv
// wolfram_lut: runtime-reprogrammable N-input truth-table cell.
// It evaluates table_q[2^N_IN-1-in] and registers the result. The table is
// loaded bit-serially, MSB first, over a valid/ready handshake, and resets to INIT.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid, in   evaluation request and logic inputs (in[N_IN-1] = in1)
//   out, out_valid registered result and its one-cycle update strobe
//   cfg_valid, cfg_ready, cfg_bit  serial table-load handshake
//   cfg_abort      discard the in-progress load
//   cfg_done       one-cycle pulse after a full table is committed
//   table_q        active table (readback)
//
// Optional feature macro: WOLFRAM_LUT_SHADOW_EN
//   defined   : bits collect in a shadow register and commit atomically
//   undefined : bits shift straight into the active table (no shadow)

module wolfram_lut #(
  parameter int unsigned               N_IN = 3,
  parameter logic [(1 << N_IN)-1:0]    INIT = 8'h69
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [N_IN-1:0]         in,
  output logic                    out,
  output logic                    out_valid,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic                    cfg_bit,
  input  logic                    cfg_abort,
  output logic                    cfg_done,
  output logic [(1 << N_IN)-1:0]  table_q
);

  localparam int unsigned W  = 1 << N_IN;
  localparam int unsigned CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   count_q;
  logic [W-1:0]    table_r;
  logic            out_r;
  logic            out_valid_r;
  logic            done_r;
  logic [N_IN-1:0] idx;
  logic            abort_c;
  logic            accept_c;
  logic            commit_c;

`ifdef WOLFRAM_LUT_SHADOW_EN
  logic [W-1:0]    shadow_q;
`endif

  // Entry for input k sits at bit W-1-k, which is simply the bitwise inverse of k.
  assign idx = ~in;

  // Ready is forced low while rst is asserted so nothing is consumed in the reset cycle.
  assign cfg_ready = (state_q != ST_DONE) && !rst;

  // Abort beats a bit offered in the same cycle.
  assign abort_c  = cfg_abort && (state_q != ST_DONE);
  assign accept_c = cfg_valid && cfg_ready && !abort_c;
  assign commit_c = accept_c && (count_q == CW'(W - 1));

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign cfg_done  = done_r;
  assign table_q   = table_r;

  // Config FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Config FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (abort_c)       state_d = ST_IDLE;
        else if (accept_c) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort_c)       state_d = ST_IDLE;
        else if (commit_c) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Evaluation pipeline: lookup uses the table as it stands before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= in_valid;
      if (in_valid) begin
        out_r <= table_r[idx];
      end
    end
  end

  // Load counter and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= commit_c;
      if (abort_c || commit_c) begin
        count_q <= '0;
      end else if (accept_c) begin
        count_q <= count_q + CW'(1);
      end
    end
  end

`ifdef WOLFRAM_LUT_SHADOW_EN
  // Double-buffered table: shadow collects bits, active table changes only on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      table_r  <= INIT;
    end else if (abort_c) begin
      shadow_q <= '0;
    end else if (commit_c) begin
      shadow_q <= '0;
      table_r  <= {shadow_q[W-2:0], cfg_bit};
    end else if (accept_c) begin
      shadow_q <= {shadow_q[W-2:0], cfg_bit};
    end
  end
`else
  // Single-buffered table: accepted bits shift straight into the active table.
  always_ff @(posedge clk) begin
    if (rst) begin
      table_r <= INIT;
    end else if (accept_c) begin
      table_r <= {table_r[W-2:0], cfg_bit};
    end
  end
`endif

endmodule

// File: tb/tb_wolfram_lut.sv
// Directed self-checking bench for wolfram_lut (N_IN=3, INIT=8'h69).
module tb_wolfram_lut;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in;
  logic       out;
  logic       out_valid;
  logic       cfg_valid;
  logic       cfg_ready;
  logic       cfg_bit;
  logic       cfg_abort;
  logic       cfg_done;
  logic [7:0] table_q;

  int n_cmp  = 0;
  int n_fail = 0;

  wolfram_lut #(.N_IN(3), .INIT(8'h69)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .out(out),
    .out_valid(out_valid), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bit(cfg_bit), .cfg_abort(cfg_abort), .cfg_done(cfg_done),
    .table_q(table_q)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in = '0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Shift a full word MSB first, then spend the DONE cycle with cfg_valid=keep.
  task automatic load_word(input logic [7:0] w, input logic keep);
    for (int i = 0; i < 8; i++) begin
      cfg_valid = 1'b1;
      cfg_bit   = w[7-i];
      tick();
      if (i < 7) begin
        n_cmp++;
        if (cfg_done !== 1'b0) begin
          n_fail++; $display("FAIL load_early_done bit=%0d got=%b want=0", i, cfg_done);
        end
      end
    end
    n_cmp++;
    if (cfg_done !== 1'b1 || cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL load_done_cycle got done=%b ready=%b want done=1 ready=0", cfg_done, cfg_ready);
    end
    n_cmp++;
    if (table_q !== w) begin
      n_fail++; $display("FAIL load_commit got=%h want=%h", table_q, w);
    end
    cfg_valid = keep;
    cfg_bit   = 1'b1;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (cfg_done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_after_done got done=%b ready=%b want done=0 ready=1", cfg_done, cfg_ready);
    end
  endtask

  task automatic sweep(input logic [7:0] exp_bits, input string name);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in       = 3'(k);
      tick();
      n_cmp++;
      if (out !== exp_bits[k] || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL %s in=%0d got out=%b vld=%b want out=%b vld=1", name, k, out, out_valid, exp_bits[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || out !== exp_bits[7]) begin
      n_fail++; $display("FAIL %s_hold got out=%b vld=%b want out=%b vld=0", name, out, out_valid, exp_bits[7]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in = '0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    #1;
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_low got=%b want=0", cfg_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out !== 1'b0 || out_valid !== 1'b0 || cfg_done !== 1'b0 || cfg_ready !== 1'b1 || table_q !== 8'h69) begin
      n_fail++; $display("FAIL reset_state got out=%b vld=%b done=%b rdy=%b tbl=%h want 0 0 0 1 69",
                         out, out_valid, cfg_done, cfg_ready, table_q);
    end
  endtask

  task automatic test_parity();
    // Odd parity of in = 0..7: 0,1,1,0,1,0,0,1 (bit k = expected for in=k)
    sweep(8'b1001_0110, "parity_sweep");
  endtask

  task automatic test_nor3();
    load_word(8'h80, 1'b0);
    sweep(8'b0000_0001, "nor3_sweep");
  endtask

  task automatic test_same_cycle();
    logic exp_first;
`ifdef WOLFRAM_LUT_SHADOW_EN
    exp_first = 1'b1;  // old 0x69 still active
`else
    exp_first = 1'b0;  // seven zeros already shifted: table is 0x80
`endif
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      tick();
    end
    in_valid = 1'b1; in = 3'b001;
    tick();
    cfg_valid = 1'b0;
    n_cmp++;
    if (out !== exp_first || cfg_done !== 1'b1) begin
      n_fail++; $display("FAIL same_cycle_old got out=%b done=%b want out=%b done=1", out, cfg_done, exp_first);
    end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out !== 1'b0 || table_q !== 8'h00) begin
      n_fail++; $display("FAIL same_cycle_new got out=%b tbl=%h want out=0 tbl=00", out, table_q);
    end
  endtask

  task automatic test_abort();
    logic [7:0] exp_tbl;
`ifdef WOLFRAM_LUT_SHADOW_EN
    exp_tbl = 8'h00;
`else
    exp_tbl = 8'h1F;
`endif
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick();
    end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    n_cmp++;
    if (table_q !== exp_tbl || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_table got tbl=%h rdy=%b want tbl=%h rdy=1", table_q, cfg_ready, exp_tbl);
    end
    tick();
    n_cmp++;
    if (cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done got=%b want=0", cfg_done);
    end
    load_word(8'hA5, 1'b0);
  endtask

  task automatic test_back_to_back();
    // A bit offered in the DONE cycle must not be consumed.
    load_word(8'hF0, 1'b1);
    load_word(8'h0F, 1'b0);
  endtask

  task automatic test_rst_mid_load();
    load_word(8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      tick();
    end
    do_reset();
    #1;
    n_cmp++;
    if (table_q !== 8'h69 || out !== 1'b0 || cfg_ready !== 1'b1 || cfg_done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_load got tbl=%h out=%b rdy=%b done=%b want 69 0 1 0",
                         table_q, out, cfg_ready, cfg_done);
    end
    // Count must be back at zero: a fresh load commits on exactly the 8th bit.
    load_word(8'h3C, 1'b0);
  endtask

  task automatic test_partial_shift();
    logic [7:0] exp_tbl;
    logic       exp_out;
`ifdef WOLFRAM_LUT_SHADOW_EN
    exp_tbl = 8'h69; exp_out = 1'b0;
`else
    exp_tbl = 8'h9F; exp_out = 1'b1;
`endif
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    n_cmp++;
    if (table_q !== exp_tbl) begin
      n_fail++; $display("FAIL partial_table got=%h want=%h", table_q, exp_tbl);
    end
    in_valid = 1'b1; in = 3'd3;
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out !== exp_out) begin
      n_fail++; $display("FAIL partial_eval got=%b want=%b", out, exp_out);
    end
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_parity();
    test_nor3();
    test_same_cycle();
    test_abort();
    test_back_to_back();
    test_rst_mid_load();
    test_partial_shift();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
